counter_hist_ctrl: RTL and testbench

//  Histogram controller sequencing the dual-port counter SRAM (1-cycle registered read).

---
 rtl/counter_hist_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_counter_hist_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_hist_ctrl.sv
// Histogram controller: read-modify-write bin increments on SRAM port A, pipelined bus reads on port B, zero sweep after reset/clear.
// Latency: event RMW takes 2 cycles (RD, WR), 1 event / 2 cycles max; bus read ack 2 cycles after the request is sampled.
// Backpressure: o_evt_ready low outside IDLE/WR, while disabled or with a clear pending; bus reads are never stalled.
// Build option: define COUNTER_HIST_SAT_EN to saturate bins at all-ones (default build wraps to 0); overflow flag is set either way.

module counter_hist_ctrl #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 18,
  parameter int DEPTH      = 4096
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_enable,
  input  logic                  i_clear,
  output logic                  o_clear_busy,
  input  logic                  i_evt_valid,
  input  logic [ADDR_WIDTH-1:0] i_evt_bin,
  output logic                  o_evt_ready,
  output logic                  o_overflow,
  input  logic                  i_rd_req,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic                  o_rd_ack,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic [ADDR_WIDTH-1:0] o_sram_addr_a,
  output logic                  o_sram_we_a,
  output logic [DATA_WIDTH-1:0] o_sram_data_a,
  input  logic [DATA_WIDTH-1:0] i_sram_data_a,
  output logic [ADDR_WIDTH-1:0] o_sram_addr_b,
  output logic                  o_sram_we_b,
  output logic [DATA_WIDTH-1:0] o_sram_data_b,
  input  logic [DATA_WIDTH-1:0] i_sram_data_b
);

  // Last address written by the zero sweep.
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_INIT = 3'd0,  // one cycle after reset, then sweep
    S_CLR  = 3'd1,  // zero sweep, one bin per cycle
    S_IDLE = 3'd2,  // waiting for an event or a clear request
    S_RD   = 3'd3,  // SRAM samples the latched bin address
    S_WR   = 3'd4   // write back read data + 1
  } state_t;

  state_t                  state_q;
  state_t                  state_d;

  // Port A address: sweep pointer while clearing, latched event bin during RMW.
  logic [ADDR_WIDTH-1:0]   addr_a_q;
  logic                    clr_pend_q;
  logic                    ovf_q;

  // Strobes from the FSM to the datapath registers.
  logic                    enter_clr;
  logic                    step_sweep;
  logic                    load_bin;
  logic                    set_ovf;

  logic                    evt_rdy;
  logic                    at_max;
  logic [DATA_WIDTH-1:0]   inc_data;

  // Bus read pipeline: address stage, SRAM stage, output stage.
  logic [ADDR_WIDTH-1:0]   addr_b_q;
  logic                    rd_p1_q;
  logic                    rd_p2_q;

  // Increment value is combinational from the SRAM output so WR can write it in the same cycle.
  assign at_max = &i_sram_data_a;

`ifdef COUNTER_HIST_SAT_EN
  assign inc_data = at_max ? i_sram_data_a : (i_sram_data_a + DATA_WIDTH'(1));
`else
  assign inc_data = i_sram_data_a + DATA_WIDTH'(1);
`endif

  // Events only accepted in IDLE or in WR (overlapping the write-back), and never once a clear is queued.
  assign evt_rdy = i_enable & ~clr_pend_q & ((state_q == S_IDLE) | (state_q == S_WR));

  assign o_evt_ready   = evt_rdy;
  assign o_overflow    = ovf_q;
  assign o_sram_addr_a = addr_a_q;
  assign o_sram_addr_b = addr_b_q;
  assign o_sram_we_b   = 1'b0;
  assign o_sram_data_b = '0;

  // State register; reset aborts any sweep or RMW and restarts from INIT.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic, port A write controls and datapath strobes.
  always_comb begin
    state_d       = state_q;
    o_clear_busy  = 1'b0;
    o_sram_we_a   = 1'b0;
    o_sram_data_a = '0;
    enter_clr     = 1'b0;
    step_sweep    = 1'b0;
    load_bin      = 1'b0;
    set_ovf       = 1'b0;
    case (state_q)
      S_INIT: begin
        o_clear_busy = 1'b1;
        enter_clr    = 1'b1;
        state_d      = S_CLR;
      end
      S_CLR: begin
        o_clear_busy = 1'b1;
        o_sram_we_a  = 1'b1;
        step_sweep   = 1'b1;
        if (addr_a_q == LAST_ADDR) begin
          state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        if (clr_pend_q) begin
          enter_clr = 1'b1;
          state_d   = S_CLR;
        end else if (evt_rdy && i_evt_valid) begin
          load_bin = 1'b1;
          state_d  = S_RD;
        end
      end
      S_RD: begin
        state_d = S_WR;
      end
      S_WR: begin
        // The write always commits at the end of WR; a pending clear starts only after it.
        o_sram_we_a   = 1'b1;
        o_sram_data_a = inc_data;
        set_ovf       = at_max;
        if (clr_pend_q) begin
          enter_clr = 1'b1;
          state_d   = S_CLR;
        end else if (evt_rdy && i_evt_valid) begin
          load_bin = 1'b1;
          state_d  = S_RD;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_INIT;
      end
    endcase
  end

  // Port A address: restart sweep at 0, advance during sweep, or capture the accepted bin.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      addr_a_q <= '0;
    end else if (enter_clr) begin
      addr_a_q <= '0;
    end else if (step_sweep) begin
      addr_a_q <= addr_a_q + ADDR_WIDTH'(1);
    end else if (load_bin) begin
      addr_a_q <= i_evt_bin;
    end
  end

  // Clear request is held until the sweep actually starts; a pulse coinciding with sweep start is covered by it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      clr_pend_q <= 1'b0;
    end else if (enter_clr) begin
      clr_pend_q <= 1'b0;
    end else if (i_clear) begin
      clr_pend_q <= 1'b1;
    end
  end

  // Sticky overflow: set when a full bin is incremented, dropped when a sweep starts.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ovf_q <= 1'b0;
    end else if (enter_clr) begin
      ovf_q <= 1'b0;
    end else if (set_ovf) begin
      ovf_q <= 1'b1;
    end
  end

  // Bus read address stage: capture the requested bin for SRAM port B.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      addr_b_q <= '0;
    end else if (i_rd_req) begin
      addr_b_q <= i_rd_addr;
    end
  end

  // Bus read valid pipeline and output register; one read per cycle, returned in order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rd_p1_q   <= 1'b0;
      rd_p2_q   <= 1'b0;
      o_rd_ack  <= 1'b0;
      o_rd_data <= '0;
    end else begin
      rd_p1_q  <= i_rd_req;
      rd_p2_q  <= rd_p1_q;
      o_rd_ack <= rd_p2_q;
      if (rd_p2_q) begin
        o_rd_data <= i_sram_data_b;
      end
    end
  end

endmodule

// File: tb/tb_counter_hist_ctrl.sv
// Directed bench for counter_hist_ctrl with a read-first dual-port SRAM model and a backdoor write port.
// Latency: n/a (bench).
// Backpressure: events are held valid until the controller shows ready.

module tb_counter_hist_ctrl;

  localparam int AW    = 12;
  localparam int DW    = 18;
  localparam int DEPTH = 4096;
  localparam logic [DW-1:0] MAXV = 18'h3FFFF;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b1;
  logic          clear = 1'b0;
  logic          clear_busy;
  logic          evt_valid = 1'b0;
  logic [AW-1:0] evt_bin = '0;
  logic          evt_ready;
  logic          overflow;
  logic          rd_req = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_ack;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] sram_addr_a, sram_addr_b;
  logic          sram_we_a, sram_we_b;
  logic [DW-1:0] sram_data_a, sram_data_b;
  logic [DW-1:0] q_a = '0;
  logic [DW-1:0] q_b = '0;

  logic          bd_we = 1'b0;
  logic [AW-1:0] bd_addr = '0;
  logic [DW-1:0] bd_data = '0;
  logic [DW-1:0] mem [0:DEPTH-1];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  counter_hist_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst(rst), .i_enable(enable), .i_clear(clear), .o_clear_busy(clear_busy),
    .i_evt_valid(evt_valid), .i_evt_bin(evt_bin), .o_evt_ready(evt_ready), .o_overflow(overflow),
    .i_rd_req(rd_req), .i_rd_addr(rd_addr), .o_rd_ack(rd_ack), .o_rd_data(rd_data),
    .o_sram_addr_a(sram_addr_a), .o_sram_we_a(sram_we_a), .o_sram_data_a(sram_data_a), .i_sram_data_a(q_a),
    .o_sram_addr_b(sram_addr_b), .o_sram_we_b(sram_we_b), .o_sram_data_b(sram_data_b), .i_sram_data_b(q_b)
  );

  // Dual-port SRAM, 1-cycle registered read, read-first; backdoor port used only while port A is quiet.
  always_ff @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (sram_we_a) mem[sram_addr_a] <= sram_data_a;
    q_a <= mem[sram_addr_a];
    q_b <= mem[sram_addr_b];
  end

  // Backdoor write of one SRAM word, starting and ending at a negedge.
  task automatic bd_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(posedge clk); @(negedge clk);
    bd_we = 1'b0;
  endtask

  // Bus read; lat is the number of rising edges from the request-sampling edge (counted as 1) to ack visible.
  task automatic bus_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output int lat);
    rd_req = 1'b1; rd_addr = a; lat = 0; d = '0;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); @(negedge clk);
      if (i == 1) rd_req = 1'b0;
      if (rd_ack && lat == 0) begin lat = i; d = rd_data; end
    end
  endtask

  // Offer one event, wait (bounded) for acceptance, then let the RMW finish.
  task automatic send_evt(input logic [AW-1:0] b);
    int n;
    n = 0;
    evt_valid = 1'b1; evt_bin = b;
    while (!evt_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin vectors++; miscompares++; $display("FAIL evt_accept_timeout: bin %0d not accepted in 50 cycles", b); end
    @(posedge clk); @(negedge clk);
    evt_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset;
    logic [DW-1:0] d;
    int lat, cnt, rdy_err;
    @(negedge clk);
    // Dirty the bins the sweep must clear.
    bd_write(12'd0, 18'h00011);
    bd_write(12'd1, 18'h00022);
    bd_write(12'd4095, 18'h00033);
    vectors++; if (clear_busy !== 1'b1) begin miscompares++; $display("FAIL rst_busy: got %0h want 1", clear_busy); end
    vectors++; if (evt_ready !== 1'b0) begin miscompares++; $display("FAIL rst_ready: got %0h want 0", evt_ready); end
    vectors++; if (sram_we_a !== 1'b0) begin miscompares++; $display("FAIL rst_we_a: got %0h want 0", sram_we_a); end
    vectors++; if (sram_addr_a !== 12'd0) begin miscompares++; $display("FAIL rst_addr_a: got %0h want 0", sram_addr_a); end
    vectors++; if (rd_ack !== 1'b0) begin miscompares++; $display("FAIL rst_ack: got %0h want 0", rd_ack); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL rst_ovf: got %0h want 0", overflow); end
    vectors++; if (sram_we_b !== 1'b0 || sram_data_b !== 18'h0) begin miscompares++; $display("FAIL rst_port_b: got we %0h data %0h want 0 0", sram_we_b, sram_data_b); end
    rst = 1'b0;
    cnt = 0; rdy_err = 0;
    while (clear_busy && cnt < 5000) begin
      if (evt_ready) rdy_err++;
      cnt++;
      @(negedge clk);
    end
    vectors++; if (cnt !== DEPTH + 1) begin miscompares++; $display("FAIL init_busy_cycles: got %0d want %0d", cnt, DEPTH + 1); end
    vectors++; if (rdy_err !== 0) begin miscompares++; $display("FAIL init_ready_low: got %0d ready cycles want 0", rdy_err); end
    bus_read(12'd0, d, lat);
    vectors++; if (d !== 18'h0 || lat !== 3) begin miscompares++; $display("FAIL read_bin0: got %0h lat %0d want 0 lat 3", d, lat); end
    bus_read(12'd1, d, lat);
    vectors++; if (d !== 18'h0 || lat !== 3) begin miscompares++; $display("FAIL read_bin1: got %0h lat %0d want 0 lat 3", d, lat); end
    bus_read(12'd4095, d, lat);
    vectors++; if (d !== 18'h0 || lat !== 3) begin miscompares++; $display("FAIL read_bin4095: got %0h lat %0d want 0 lat 3", d, lat); end
  endtask

  task automatic test_back_to_back;
    int t [3];
    int n;
    logic [DW-1:0] d;
    int lat;
    n = 0;
    evt_valid = 1'b1; evt_bin = 12'd5;
    for (int c = 0; c < 20 && n < 3; c++) begin
      if (evt_ready) begin t[n] = c; n++; end
      @(posedge clk); @(negedge clk);
    end
    evt_valid = 1'b0;
    vectors++; if (n !== 3) begin miscompares++; $display("FAIL b2b_accepts: got %0d want 3", n); end
    vectors++; if (n == 3 && (t[1] - t[0] !== 2 || t[2] - t[1] !== 2)) begin miscompares++; $display("FAIL b2b_spacing: got %0d,%0d want 2,2", t[1] - t[0], t[2] - t[1]); end
    repeat (4) @(negedge clk);
    bus_read(12'd5, d, lat);
    vectors++; if (d !== 18'h00003) begin miscompares++; $display("FAIL b2b_bin5: got %0h want 3", d); end
    vectors++; if (lat !== 3) begin miscompares++; $display("FAIL b2b_ack_latency: got %0d want 3", lat); end
  endtask

  task automatic test_interleave;
    logic [AW-1:0] seq [3];
    logic req_hist [20];
    int idx, acks, ack_err, ord_err, lat;
    logic [DW-1:0] last, d;
    seq[0] = 12'd7; seq[1] = 12'd8; seq[2] = 12'd7;
    idx = 0; acks = 0; ack_err = 0; ord_err = 0; last = '0;
    for (int c = 0; c < 16; c++) begin
      if (rd_ack) begin
        acks++;
        if (c < 3 || !req_hist[c-3]) ack_err++;
        if (rd_data < last) ord_err++;
        last = rd_data;
      end else if (c >= 3 && req_hist[c-3]) begin
        ack_err++;
      end
      rd_req = (c < 10); rd_addr = 12'd7; req_hist[c] = (c < 10);
      if (idx < 3) begin
        evt_valid = 1'b1; evt_bin = seq[idx];
        if (evt_ready) idx++;
      end else begin
        evt_valid = 1'b0;
      end
      @(posedge clk); @(negedge clk);
    end
    rd_req = 1'b0; evt_valid = 1'b0;
    vectors++; if (idx !== 3) begin miscompares++; $display("FAIL ilv_accepts: got %0d want 3", idx); end
    vectors++; if (acks !== 10 || ack_err !== 0) begin miscompares++; $display("FAIL ilv_ack_timing: got %0d acks %0d misplaced want 10 0", acks, ack_err); end
    vectors++; if (ord_err !== 0) begin miscompares++; $display("FAIL ilv_ack_order: got %0d decreasing want 0", ord_err); end
    repeat (3) @(negedge clk);
    bus_read(12'd7, d, lat);
    vectors++; if (d !== 18'h00002) begin miscompares++; $display("FAIL ilv_bin7: got %0h want 2", d); end
    bus_read(12'd8, d, lat);
    vectors++; if (d !== 18'h00001) begin miscompares++; $display("FAIL ilv_bin8: got %0h want 1", d); end
  endtask

  task automatic test_overflow;
    logic [DW-1:0] d, want;
    int lat;
`ifdef COUNTER_HIST_SAT_EN
    want = MAXV;
`else
    want = 18'h00000;
`endif
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_before: got %0h want 0", overflow); end
    bd_write(12'd9, MAXV);
    send_evt(12'd9);
    vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_set: got %0h want 1", overflow); end
    bus_read(12'd9, d, lat);
    vectors++; if (d !== want) begin miscompares++; $display("FAIL ovf_bin9: got %0h want %0h", d, want); end
    send_evt(12'd2);
    vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky: got %0h want 1", overflow); end
  endtask

  task automatic test_clear_mid_rmw;
    logic [DW-1:0] d;
    int lat, cnt;
    evt_valid = 1'b1; evt_bin = 12'd3;
    vectors++; if (evt_ready !== 1'b1) begin miscompares++; $display("FAIL clr_ready_idle: got %0h want 1", evt_ready); end
    @(posedge clk); @(negedge clk);
    evt_valid = 1'b0; clear = 1'b1;                    // RD cycle of bin 3
    @(posedge clk); @(negedge clk);
    clear = 1'b0;                                      // WR cycle: write of bin 3 must still happen
    vectors++; if (sram_we_a !== 1'b1 || sram_addr_a !== 12'd3 || sram_data_a !== 18'h00001) begin miscompares++; $display("FAIL clr_wr_bin3: got we %0h addr %0h data %0h want 1 3 1", sram_we_a, sram_addr_a, sram_data_a); end
    vectors++; if (evt_ready !== 1'b0 || clear_busy !== 1'b0) begin miscompares++; $display("FAIL clr_wr_flags: got ready %0h busy %0h want 0 0", evt_ready, clear_busy); end
    @(posedge clk); @(negedge clk);
    vectors++; if (mem[3] !== 18'h00001) begin miscompares++; $display("FAIL clr_commit_bin3: got %0h want 1", mem[3]); end
    vectors++; if (clear_busy !== 1'b1 || sram_addr_a !== 12'd0 || overflow !== 1'b0) begin miscompares++; $display("FAIL clr_sweep_start: got busy %0h addr %0h ovf %0h want 1 0 0", clear_busy, sram_addr_a, overflow); end
    cnt = 0;
    while (clear_busy && cnt < 5000) begin cnt++; @(negedge clk); end
    vectors++; if (cnt !== DEPTH) begin miscompares++; $display("FAIL clr_sweep_cycles: got %0d want %0d", cnt, DEPTH); end
    bus_read(12'd3, d, lat);
    vectors++; if (d !== 18'h0) begin miscompares++; $display("FAIL clr_bin3: got %0h want 0", d); end
    bus_read(12'd5, d, lat);
    vectors++; if (d !== 18'h0) begin miscompares++; $display("FAIL clr_bin5: got %0h want 0", d); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL clr_ovf: got %0h want 0", overflow); end
  endtask

  task automatic test_reset_mid_sweep;
    logic [DW-1:0] d;
    int lat, n, cnt;
    bd_write(12'd10, MAXV);
    send_evt(12'd10);
    vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL mid_ovf_pre: got %0h want 1", overflow); end
    rst = 1'b1;
    #1;
    vectors++; if (overflow !== 1'b0 || clear_busy !== 1'b1) begin miscompares++; $display("FAIL mid_rst1: got ovf %0h busy %0h want 0 1", overflow, clear_busy); end
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (!(clear_busy && sram_addr_a == 12'd100) && n < 300) begin @(negedge clk); n++; end
    vectors++; if (n >= 300) begin miscompares++; $display("FAIL mid_reach_100: got timeout want addr 100"); end
    rst = 1'b1;
    #1;
    vectors++; if (sram_addr_a !== 12'd0 || sram_we_a !== 1'b0 || clear_busy !== 1'b1) begin miscompares++; $display("FAIL mid_rst_outputs: got addr %0h we %0h busy %0h want 0 0 1", sram_addr_a, sram_we_a, clear_busy); end
    vectors++; if (evt_ready !== 1'b0 || rd_ack !== 1'b0 || sram_data_a !== 18'h0 || sram_addr_b !== 12'd0) begin miscompares++; $display("FAIL mid_rst_misc: got rdy %0h ack %0h da %0h ab %0h want 0 0 0 0", evt_ready, rd_ack, sram_data_a, sram_addr_b); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    vectors++; if (sram_addr_a !== 12'd0 || sram_we_a !== 1'b1) begin miscompares++; $display("FAIL mid_restart0: got addr %0h we %0h want 0 1", sram_addr_a, sram_we_a); end
    @(posedge clk); @(negedge clk);
    vectors++; if (sram_addr_a !== 12'd1) begin miscompares++; $display("FAIL mid_restart1: got addr %0h want 1", sram_addr_a); end
    cnt = 0;
    while (clear_busy && cnt < 5000) begin cnt++; @(negedge clk); end
    vectors++; if (cnt !== DEPTH - 1) begin miscompares++; $display("FAIL mid_sweep_rest: got %0d want %0d", cnt, DEPTH - 1); end
    bus_read(12'd10, d, lat);
    vectors++; if (d !== 18'h0) begin miscompares++; $display("FAIL mid_bin10: got %0h want 0", d); end
  endtask

  initial begin
    test_reset;
    test_back_to_back;
    test_interleave;
    test_overflow;
    test_clear_mid_rmw;
    test_reset_mid_sweep;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion want finish before 1000000");
    $fatal(1, "watchdog expired");
  end

endmodule
